// File: rtl/gray_frame_loader_pkg.sv
// Shared types and constants for the grayscale frame loader.
package gray_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // BT.601-style luma weights in Q8; they sum to 256 so the result never exceeds 255.
    localparam int COEF_R     = 77;
    localparam int COEF_G     = 150;
    localparam int COEF_B     = 29;
    localparam int GRAY_SHIFT = 8;

    localparam int MIN_DIM    = 3;

endpackage

// File: rtl/gray_frame_loader_if.sv
// Stream-in / random-read bus between the pixel source, the loader and the Sobel stage.
interface gray_frame_loader_if #(
    parameter int ADDR_W = 19
);
    logic              start;
    logic [15:0]       W;
    logic [15:0]       H;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [15:0]       rd_h;
    logic [15:0]       rd_w;
    logic [7:0]        rd_data;
    logic              all_loaded;
    logic              size_err;
    logic [ADDR_W-1:0] pix_count;

    modport master (
        output start, W, H, in_valid, in_data, rd_h, rd_w,
        input  in_ready, rd_data, all_loaded, size_err, pix_count
    );

    modport slave (
        input  start, W, H, in_valid, in_data, rd_h, rd_w,
        output in_ready, rd_data, all_loaded, size_err, pix_count
    );

endinterface

// File: rtl/gray_frame_loader_rgb_to_gray.sv
// Combinational RGB888 to 8-bit luma conversion.
module rgb_to_gray
    import gray_frame_pkg::*;
(
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic [7:0] o_gray
);

    assign o_gray = 8'((16'(COEF_R) * 16'(i_r)
                      + 16'(COEF_G) * 16'(i_g)
                      + 16'(COEF_B) * 16'(i_b)) >> GRAY_SHIFT);

endmodule

// File: rtl/gray_frame_loader.sv
// Loads one raster frame into an on-chip buffer and serves registered (row, col) reads.
// Build macro GRAY_BYPASS_EN: input stream is already gray, one byte per pixel.
//
//   state | meaning
//   IDLE  | waiting for a start with a legal frame size
//   LOAD  | accepting stream bytes, writing one pixel per completed pixel
//   DONE  | frame complete, all_loaded high, buffer readable
module gray_frame_loader
    import gray_frame_pkg::*;
#(
    parameter int MAX_W  = 640,
    parameter int MAX_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rstn,
    gray_frame_loader_if.slave bus
);

    localparam int DEPTH = MAX_W * MAX_H;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_w;
    logic [15:0]       r_h;
    logic [ADDR_W-1:0] r_last_idx;
    logic [ADDR_W-1:0] r_pix_count;
    logic              r_all_loaded;
    logic              r_size_err;
    logic [7:0]        r_rd_data;
    logic [7:0]        r_mem [DEPTH];

    logic              w_size_ok;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_hs;
    logic              w_pix_we;
    logic              w_last;
    logic [7:0]        w_gray;
    logic              w_rd_in_range;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_size_ok = (bus.W >= 16'(MIN_DIM)) && (bus.H >= 16'(MIN_DIM))
                    && (bus.W <= 16'(MAX_W))   && (bus.H <= 16'(MAX_H));

    // A start during LOAD is ignored outright, including size checking.
    assign w_start_ok  = bus.start &&  w_size_ok && (r_state != LOAD);
    assign w_start_bad = bus.start && !w_size_ok && (r_state != LOAD);

    assign w_hs   = bus.in_valid && (r_state == LOAD);
    assign w_last = w_pix_we && (r_pix_count == r_last_idx);

`ifdef GRAY_BYPASS_EN
    assign w_gray   = bus.in_data;
    assign w_pix_we = w_hs;
`else
    logic [1:0] r_phase;
    logic [7:0] r_r;
    logic [7:0] r_g;

    rgb_to_gray u_rgb_to_gray (
        .i_r    (r_r),
        .i_g    (r_g),
        .i_b    (bus.in_data),
        .o_gray (w_gray)
    );

    assign w_pix_we = w_hs && (r_phase == 2'd2);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase <= 2'd0;
            r_r     <= 8'd0;
            r_g     <= 8'd0;
        end else if (w_start_ok) begin
            r_phase <= 2'd0;
        end else if (w_hs) begin
            case (r_phase)
                2'd0: begin
                    r_r     <= bus.in_data;
                    r_phase <= 2'd1;
                end
                2'd1: begin
                    r_g     <= bus.in_data;
                    r_phase <= 2'd2;
                end
                default: r_phase <= 2'd0;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = LOAD;
            LOAD:    if (w_last)     w_state_nxt = DONE;
            DONE:    if (w_start_ok) w_state_nxt = LOAD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_w          <= 16'd0;
            r_h          <= 16'd0;
            r_last_idx   <= '0;
            r_pix_count  <= '0;
            r_all_loaded <= 1'b0;
            r_size_err   <= 1'b0;
        end else begin
            r_size_err <= w_start_bad;
            if (w_start_ok) begin
                r_w          <= bus.W;
                r_h          <= bus.H;
                r_last_idx   <= ADDR_W'(32'(bus.W) * 32'(bus.H) - 32'd1);
                r_pix_count  <= '0;
                r_all_loaded <= 1'b0;
            end else if (w_pix_we) begin
                r_pix_count <= r_pix_count + 1'b1;
                if (w_last) begin
                    r_all_loaded <= 1'b1;
                end
            end
        end
    end

    // Buffer is not reset so it maps onto a plain 1R1W RAM.
    always_ff @(posedge clk) begin
        if (w_pix_we) begin
            r_mem[r_pix_count] <= w_gray;
        end
    end

    assign w_rd_in_range = (bus.rd_h < r_h) && (bus.rd_w < r_w);
    assign w_rd_addr     = ADDR_W'(32'(bus.rd_h) * 32'(r_w) + 32'(bus.rd_w));

    // Non-blocking read alongside the write gives read-first on address collisions.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_data <= 8'd0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[w_rd_addr];
        end else begin
            r_rd_data <= 8'd0;
        end
    end

    assign bus.in_ready   = (r_state == LOAD);
    assign bus.rd_data    = r_rd_data;
    assign bus.all_loaded = r_all_loaded;
    assign bus.size_err   = r_size_err;
    assign bus.pix_count  = r_pix_count;

endmodule

// File: tb/tb_gray_frame_loader.sv
// Directed self-checking bench for gray_frame_loader (RGB mode, or gray mode under GRAY_BYPASS_EN).
module tb_gray_frame_loader;

    localparam int ADDR_W = 19;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gray_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

    gray_frame_loader #(
        .MAX_W  (640),
        .MAX_H  (480),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic [7:0] gray, input int gap);
`ifdef GRAY_BYPASS_EN
        send_byte(gray, gap);
`else
        send_byte(r, gap);
        send_byte(g, gap);
        send_byte(b, gap);
`endif
    endtask

    task automatic do_start(input int w, input int h);
        bus.start = 1'b1;
        bus.W     = 16'(w);
        bus.H     = 16'(h);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic read_px(input int h, input int w, output logic [7:0] d);
        bus.rd_h = 16'(h);
        bus.rd_w = 16'(w);
        @(negedge clk);
        d = bus.rd_data;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
        n_cmp++; if (bus.all_loaded !== 1'b0) begin n_bad++; $display("FAIL rst_all_loaded got %0b want 0", bus.all_loaded); end
        n_cmp++; if (bus.size_err !== 1'b0) begin n_bad++; $display("FAIL rst_size_err got %0b want 0", bus.size_err); end
        n_cmp++; if (bus.pix_count !== '0) begin n_bad++; $display("FAIL rst_pix_count got %0d want 0", bus.pix_count); end
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd_data got %0h want 0", bus.rd_data); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_white();
        logic [7:0] d;
        do_start(3, 3);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL white_in_ready got %0b want 1", bus.in_ready); end
        for (int i = 0; i < 8; i++) send_pixel(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
        n_cmp++; if (bus.all_loaded !== 1'b0) begin n_bad++; $display("FAIL white_early_loaded got %0b want 0", bus.all_loaded); end
        n_cmp++; if (bus.pix_count !== 19'd8) begin n_bad++; $display("FAIL white_pix8 got %0d want 8", bus.pix_count); end
        send_pixel(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
        n_cmp++; if (bus.all_loaded !== 1'b1) begin n_bad++; $display("FAIL white_loaded got %0b want 1", bus.all_loaded); end
        n_cmp++; if (bus.pix_count !== 19'd9) begin n_bad++; $display("FAIL white_pix9 got %0d want 9", bus.pix_count); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL white_done_ready got %0b want 0", bus.in_ready); end
        send_byte(8'h00, 0);
        n_cmp++; if (bus.pix_count !== 19'd9) begin n_bad++; $display("FAIL white_drop_pix got %0d want 9", bus.pix_count); end
        n_cmp++; if (bus.all_loaded !== 1'b1) begin n_bad++; $display("FAIL white_drop_loaded got %0b want 1", bus.all_loaded); end
        for (int i = 0; i < 9; i++) begin
            read_px(i / 3, i % 3, d);
            n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL white_rd%0d got %0h want ff", i, d); end
        end
    endtask

    task automatic test_primaries();
        logic [7:0] d;
        do_start(3, 3);
        n_cmp++; if (bus.all_loaded !== 1'b0) begin n_bad++; $display("FAIL prim_restart_loaded got %0b want 0", bus.all_loaded); end
        n_cmp++; if (bus.pix_count !== '0) begin n_bad++; $display("FAIL prim_restart_pix got %0d want 0", bus.pix_count); end
        send_pixel(8'hFF, 8'h00, 8'h00, 8'h4C, 0);
        send_pixel(8'h00, 8'hFF, 8'h00, 8'h95, 0);
        send_pixel(8'h00, 8'h00, 8'hFF, 8'h1C, 0);
        for (int i = 3; i < 9; i++) send_pixel(8'h80, 8'h80, 8'h80, 8'h80, 0);
        read_px(0, 0, d);
        n_cmp++; if (d !== 8'h4C) begin n_bad++; $display("FAIL prim_red got %0h want 4c", d); end
        read_px(0, 1, d);
        n_cmp++; if (d !== 8'h95) begin n_bad++; $display("FAIL prim_green got %0h want 95", d); end
        bus.rd_h = 16'd0;
        bus.rd_w = 16'd2;
        #1;
        n_cmp++; if (bus.rd_data !== 8'h95) begin n_bad++; $display("FAIL prim_latency got %0h want 95", bus.rd_data); end
        @(negedge clk);
        n_cmp++; if (bus.rd_data !== 8'h1C) begin n_bad++; $display("FAIL prim_blue got %0h want 1c", bus.rd_data); end
        read_px(1, 1, d);
        n_cmp++; if (d !== 8'h80) begin n_bad++; $display("FAIL prim_mid got %0h want 80", d); end
    endtask

    task automatic test_size_err();
        pulse_reset();
        do_start(2, 5);
        n_cmp++; if (bus.size_err !== 1'b1) begin n_bad++; $display("FAIL serr_w2 got %0b want 1", bus.size_err); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL serr_w2_ready got %0b want 0", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.size_err !== 1'b0) begin n_bad++; $display("FAIL serr_w2_pulse got %0b want 0", bus.size_err); end
        do_start(641, 4);
        n_cmp++; if (bus.size_err !== 1'b1) begin n_bad++; $display("FAIL serr_w641 got %0b want 1", bus.size_err); end
        @(negedge clk);
        n_cmp++; if (bus.size_err !== 1'b0) begin n_bad++; $display("FAIL serr_w641_pulse got %0b want 0", bus.size_err); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL serr_w641_ready got %0b want 0", bus.in_ready); end
        do_start(640, 480);
        n_cmp++; if (bus.size_err !== 1'b0) begin n_bad++; $display("FAIL serr_max_ok got %0b want 0", bus.size_err); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL serr_max_ready got %0b want 1", bus.in_ready); end
        do_start(2, 2);
        n_cmp++; if (bus.size_err !== 1'b0) begin n_bad++; $display("FAIL serr_in_load got %0b want 0", bus.size_err); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL serr_in_load_ready got %0b want 1", bus.in_ready); end
        pulse_reset();
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        logic [7:0] v;
        do_start(4, 3);
        bus.rd_h = 16'd0;
        bus.rd_w = 16'd0;
        send_pixel(8'h11, 8'h11, 8'h11, 8'h11, 1);
        n_cmp++; if (bus.rd_data !== 8'h4C) begin n_bad++; $display("FAIL gap_read_first got %0h want 4c", bus.rd_data); end
        @(negedge clk);
        n_cmp++; if (bus.rd_data !== 8'h11) begin n_bad++; $display("FAIL gap_read_new got %0h want 11", bus.rd_data); end
        for (int i = 1; i < 12; i++) begin
            v = 8'(8'h11 * (i + 1));
            send_pixel(v, v, v, v, i % 3);
        end
        n_cmp++; if (bus.pix_count !== 19'd12) begin n_bad++; $display("FAIL gap_pix got %0d want 12", bus.pix_count); end
        n_cmp++; if (bus.all_loaded !== 1'b1) begin n_bad++; $display("FAIL gap_loaded got %0b want 1", bus.all_loaded); end
        for (int i = 0; i < 12; i++) begin
            read_px(i / 4, i % 4, d);
            v = 8'(8'h11 * (i + 1));
            n_cmp++; if (d !== v) begin n_bad++; $display("FAIL gap_rd%0d got %0h want %0h", i, d, v); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        logic [7:0] v;
        do_start(3, 3);
        for (int i = 0; i < 10; i++) send_byte(8'h00, 0);
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.pix_count !== '0) begin n_bad++; $display("FAIL mid_rst_pix got %0d want 0", bus.pix_count); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got %0b want 0", bus.in_ready); end
        rstn = 1'b1;
        @(negedge clk);
        do_start(3, 3);
        for (int i = 0; i < 8; i++) begin
            v = 8'(8'h30 + i);
            send_pixel(v, v, v, v, 0);
        end
        n_cmp++; if (bus.all_loaded !== 1'b0) begin n_bad++; $display("FAIL mid_early_loaded got %0b want 0", bus.all_loaded); end
        send_pixel(8'h38, 8'h38, 8'h38, 8'h38, 0);
        n_cmp++; if (bus.all_loaded !== 1'b1) begin n_bad++; $display("FAIL mid_loaded got %0b want 1", bus.all_loaded); end
        read_px(0, 0, d);
        n_cmp++; if (d !== 8'h30) begin n_bad++; $display("FAIL mid_px0 got %0h want 30", d); end
        read_px(1, 2, d);
        n_cmp++; if (d !== 8'h35) begin n_bad++; $display("FAIL mid_px5 got %0h want 35", d); end
        read_px(2, 2, d);
        n_cmp++; if (d !== 8'h38) begin n_bad++; $display("FAIL mid_px8 got %0h want 38", d); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] d;
        read_px(3, 0, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL oor_row got %0h want 0", d); end
        read_px(0, 3, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL oor_col got %0h want 0", d); end
        read_px(1, 0, d);
        n_cmp++; if (d !== 8'h33) begin n_bad++; $display("FAIL oor_inrange got %0h want 33", d); end
    endtask

`ifdef GRAY_BYPASS_EN
    task automatic test_bypass();
        logic [7:0] d;
        do_start(3, 3);
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i), 0);
        n_cmp++; if (bus.all_loaded !== 1'b1) begin n_bad++; $display("FAIL byp_loaded got %0b want 1", bus.all_loaded); end
        read_px(1, 1, d);
        n_cmp++; if (d !== 8'h14) begin n_bad++; $display("FAIL byp_center got %0h want 14", d); end
    endtask
`endif

    initial begin
        bus.start    = 1'b0;
        bus.W        = 16'd0;
        bus.H        = 16'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.rd_h     = 16'd0;
        bus.rd_w     = 16'd0;
        test_reset();
        test_full_white();
        test_primaries();
        test_size_err();
        test_gaps();
        test_reset_mid_load();
        test_out_of_range();
`ifdef GRAY_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
